// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and word geometry.
package imem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StCsum,
    StDone
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  // Byte-to-word address shift; the fetch PC advances by the same stride.
  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words. The word output already includes the
// byte being accepted this cycle, so word_full and word are valid together on the 4th byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clr,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  always_comb begin
    word = word_q;
    if (in_valid) begin
      word[{cnt_q, 3'b000} +: 8] = in_data;
    end
  end

  assign word_full = in_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (in_valid) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream -> word writes from address 0, holding the core in reset
// until a load completes. Define IMEM_LOADER_CSUM_EN to append and verify a trailing checksum word.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [CNT_W-1:0] MaxWords = CNT_W'(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] word_idx_q;
  logic [CNT_W-1:0] num_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             cpu_reset_q;
  logic             error_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0]      sum_q;
`endif

  logic        start_ok;
  logic        start_bad;
  logic        csum_bad;
  logic        last_word;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic        pk_full;

  assign pk_valid  = byte_valid && byte_ready;
  assign last_word = (word_idx_q + CNT_W'(1)) == num_q;

  byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (pk_valid),
    .in_data   (byte_data),
    .clr       (start_ok),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    csum_bad   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words > MaxWords) begin
            start_bad = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = (num_words == '0) ? StDone : StCollect;
          end
        end
      end
      StCollect: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (pk_full) state_d = StWrite;
      end
      StWrite: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StCollect;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      StCsum: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (pk_full) begin
          state_d  = StDone;
          csum_bad = (pk_word != sum_q);
        end
      end
`endif
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      num_q       <= '0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      cpu_reset_q <= 1'b1;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q       <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      if (start_bad) error_q <= 1'b1;
      if (start_ok) begin
        error_q    <= 1'b0;
        num_q      <= num_words;
        word_idx_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        sum_q      <= 32'd0;
`endif
      end
      if (state_q == StCollect && pk_full) begin
        wdata_q <= pk_word;
        addr_q  <= 32'(word_idx_q) << WORD_SHIFT;
      end
      if (state_q == StWrite) begin
        word_idx_q <= word_idx_q + CNT_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
        sum_q      <= sum_q + wdata_q;
`endif
      end
      // Release is decided on entry to DONE so cpu_reset falls together with done.
      if (csum_bad) begin
        error_q     <= 1'b1;
        cpu_reset_q <= 1'b1;
      end else if (state_d == StDone) begin
        cpu_reset_q <= 1'b0;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign error     = error_q;

endmodule
